// File: rtl/bcd_fmt_pkg.sv
// rtl/bcd_fmt_pkg.sv - shared types and constants for the BCD display formatter
//
// Purpose: FSM state encoding and width/limit helpers used by the formatter
//          top and its interface.
// Contents:
//   bcd_state_t     FSM states IDLE, SHIFT, FINISH
//   bcd_width()     packed BCD width for a digit count (4 bits per digit)
//   max_decimal()   largest value showable with a digit count (10**d - 1)
package bcd_fmt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } bcd_state_t;

  localparam int DEFAULT_BIN_W  = 14;
  localparam int DEFAULT_DIGITS = 4;

  function automatic int bcd_width(input int digits);
    return 4 * digits;
  endfunction

  function automatic int unsigned max_decimal(input int digits);
    int unsigned r;
    r = 1;
    for (int i = 0; i < digits; i++) begin
      r = r * 10;
    end
    return r - 1;
  endfunction

endpackage

// File: rtl/bcd_display_formatter_if.sv
// rtl/bcd_display_formatter_if.sv - request/result bundle for the BCD display formatter
//
// Purpose: groups the conversion request and the result outputs.
// Signals:
//   START  conversion request, sampled on the rising clock edge
//   BIN    unsigned binary value, captured when START is accepted
//   BCD    packed BCD result, digit 0 (ones) in [3:0]
//   BUSY   high while a conversion is in progress
//   DONE   one-cycle pulse, BCD/OVF updated on the same edge
//   OVF    last accepted BIN exceeded the displayable range
// Modports: master (MCU side, drives the request), slave (formatter).
interface bcd_display_formatter_if #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
);

  logic                  START;
  logic [BIN_W-1:0]      BIN;
  logic [4*DIGITS-1:0]   BCD;
  logic                  BUSY;
  logic                  DONE;
  logic                  OVF;

  modport master (
    output START, BIN,
    input  BCD, BUSY, DONE, OVF
  );

  modport slave (
    input  START, BIN,
    output BCD, BUSY, DONE, OVF
  );

endinterface

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble nibble correction (+3 when the nibble is 5 or more)
//
// Purpose: combinational per-digit correction applied before each shift.
// Ports:
//   din   4-bit working BCD digit
//   dout  corrected digit
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/bcd_display_formatter.sv
// rtl/bcd_display_formatter.sv - iterative binary-to-BCD converter feeding the seven-segment driver
//
// Purpose: on an accepted START, converts BIN to packed BCD with one
//          shift-add-3 iteration per input bit, then publishes the result
//          (saturated to all nines with OVF set when out of range). The
//          published BCD/OVF hold between conversions so the display never
//          shows intermediate values.
// Ports:
//   CLK    system clock
//   RST_N  synchronous reset, active low
//   bus    slave side of bcd_display_formatter_if (START/BIN in,
//          BCD/BUSY/DONE/OVF out)
module bcd_display_formatter
  import bcd_fmt_pkg::*;
#(
  parameter int BIN_W  = DEFAULT_BIN_W,
  parameter int DIGITS = DEFAULT_DIGITS
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  bcd_display_formatter_if.slave  bus
);

  localparam int          BCD_W   = bcd_width(DIGITS);
  localparam int          CNT_W   = $clog2(BIN_W + 1);
  localparam int unsigned MAX_DEC = max_decimal(DIGITS);

  bcd_state_t         state_q;
  bcd_state_t         state_d;

  logic [BIN_W-1:0]   bin_shift;
  logic [BCD_W-1:0]   bcd_work;
  logic [BCD_W-1:0]   bcd_adj;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_pending;

  logic [BCD_W-1:0]   bcd_q;
  logic               ovf_q;
  logic               done_q;

  // Per-digit correction; nibbles are independent, no carry between them.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (bcd_work[4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.START) state_d = SHIFT;
      // cnt still holds the iteration count before this edge's decrement,
      // so cnt==1 marks the edge that performs the final iteration.
      SHIFT:   if (cnt == CNT_W'(1)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      bin_shift   <= '0;
      bcd_work    <= '0;
      cnt         <= '0;
      ovf_pending <= 1'b0;
      bcd_q       <= '0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.START) begin
            bin_shift   <= bus.BIN;
            bcd_work    <= '0;
            cnt         <= CNT_W'(BIN_W);
            ovf_pending <= (32'(bus.BIN) > MAX_DEC);
          end
        end
        SHIFT: begin
          {bcd_work, bin_shift} <= {bcd_adj[BCD_W-2:0], bin_shift, 1'b0};
          cnt                   <= cnt - CNT_W'(1);
        end
        FINISH: begin
          bcd_q  <= ovf_pending ? {DIGITS{4'h9}} : bcd_work;
          ovf_q  <= ovf_pending;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.BCD  = bcd_q;
  assign bus.OVF  = ovf_q;
  assign bus.DONE = done_q;
  assign bus.BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_bcd_display_formatter.sv
// tb/tb_bcd_display_formatter.sv - directed self-checking bench for bcd_display_formatter
module tb_bcd_display_formatter;

  logic CLK;
  logic RST_N;
  int   checks;
  int   errors;

  bcd_display_formatter_if #(.BIN_W(14), .DIGITS(4)) bus ();

  bcd_display_formatter #(.BIN_W(14), .DIGITS(4)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accepting edge E0; leaves START low afterwards.
  task automatic start_conv(input logic [13:0] bin);
    bus.BIN   = bin;
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
  endtask

  // Observes the 15 busy cycles (after E0..E14), then the result after E15.
  task automatic wait_done(input string tag, input logic [15:0] exp_bcd, input logic exp_ovf);
    int busy_cnt;
    busy_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.BUSY === 1'b1 && bus.DONE === 1'b0) busy_cnt++;
      step();
    end
    check({tag, "_busy15"}, busy_cnt, 15);
    check({tag, "_done"},   {31'd0, bus.DONE}, 1);
    check({tag, "_idle"},   {31'd0, bus.BUSY}, 0);
    check({tag, "_bcd"},    {16'd0, bus.BCD}, {16'd0, exp_bcd});
    check({tag, "_ovf"},    {31'd0, bus.OVF}, {31'd0, exp_ovf});
  endtask

  task automatic run(input string tag, input logic [13:0] bin, input logic [15:0] exp_bcd, input logic exp_ovf);
    start_conv(bin);
    wait_done(tag, exp_bcd, exp_ovf);
    step();
    check({tag, "_pulse"}, {31'd0, bus.DONE}, 0);
    check({tag, "_hold"},  {16'd0, bus.BCD}, {16'd0, exp_bcd});
  endtask

  int cnt_ev;

  initial begin
    checks    = 0;
    errors    = 0;
    RST_N     = 1'b0;
    bus.START = 1'b1;
    bus.BIN   = 14'd1234;
    step();
    step();
    check("rst_bcd",  {16'd0, bus.BCD}, 0);
    check("rst_busy", {31'd0, bus.BUSY}, 0);
    check("rst_done", {31'd0, bus.DONE}, 0);
    check("rst_ovf",  {31'd0, bus.OVF}, 0);
    RST_N     = 1'b1;
    bus.START = 1'b0;
    step();
    check("post_rst_busy", {31'd0, bus.BUSY}, 0);

    run("c1234",  14'd1234,  16'h1234, 1'b0);
    run("c0",     14'd0,     16'h0000, 1'b0);
    run("c255",   14'd255,   16'h0255, 1'b0);
    run("c9999",  14'd9999,  16'h9999, 1'b0);
    run("c10000", 14'd10000, 16'h9999, 1'b1);
    run("c16383", 14'd16383, 16'h9999, 1'b1);
    run("c42",    14'd42,    16'h0042, 1'b0);

    // START ignored while busy; BIN changes after capture are ignored.
    start_conv(14'd500);
    for (int i = 0; i < 4; i++) step();
    bus.BIN   = 14'd777;
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    for (int i = 0; i < 9; i++) step();
    check("ign_in_finish", {30'd0, dut.state_q}, 2);
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    check("ign_done", {31'd0, bus.DONE}, 1);
    check("ign_bcd",  {16'd0, bus.BCD}, 32'h0500);
    cnt_ev = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.DONE === 1'b1 || bus.BUSY === 1'b1) cnt_ev++;
    end
    check("ign_no_extra", cnt_ev, 0);

    // Back-to-back: accept on the first IDLE edge after FINISH.
    start_conv(14'd1);
    wait_done("b2b_first", 16'h0001, 1'b0);
    start_conv(14'd100);
    check("b2b_busy", {31'd0, bus.BUSY}, 1);
    check("b2b_prev_bcd", {16'd0, bus.BCD}, 32'h0001);
    // start_conv already consumed E0; wait_done observes from after E0.
    wait_done("b2b_second", 16'h0100, 1'b0);
    step();

    // Reset during iteration 7 aborts the conversion.
    start_conv(14'd4321);
    for (int i = 0; i < 6; i++) step();
    RST_N = 1'b0;
    step();
    check("mrst_bcd",  {16'd0, bus.BCD}, 0);
    check("mrst_busy", {31'd0, bus.BUSY}, 0);
    check("mrst_done", {31'd0, bus.DONE}, 0);
    check("mrst_ovf",  {31'd0, bus.OVF}, 0);
    RST_N  = 1'b1;
    cnt_ev = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.DONE === 1'b1) cnt_ev++;
    end
    check("mrst_no_done", cnt_ev, 0);
    run("c4321", 14'd4321, 16'h4321, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
